// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit integer ALU between two requesters (r0, r1).
// Handshakes: a request transfers on a rising edge where rN_valid && rN_ready;
// a result transfers on a rising edge where rN_rvalid && rN_rready. Payloads
// must be held stable while valid is high and ready is low.
module alu_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [5:0]       r0_op,
  input  logic [31:0]      r0_x,
  input  logic [31:0]      r0_y,
  output logic             r0_rvalid,
  input  logic             r0_rready,
  output logic [31:0]      r0_z,
  output logic             r0_ovf,
  output logic             r0_err,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [5:0]       r1_op,
  input  logic [31:0]      r1_x,
  input  logic [31:0]      r1_y,
  output logic             r1_rvalid,
  input  logic             r1_rready,
  output logic [31:0]      r1_z,
  output logic             r1_ovf,
  output logic             r1_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt,
  output logic [1:0]       dbg_state
);

  // Opcode encodings (MIPS funct field values).
  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_OR   = 6'h25;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              last_q, owner_q;
  logic [5:0]        op_q;
  logic [31:0]       x_q, y_q;
  logic [31:0]       r0_z_q, r1_z_q;
  logic              r0_ovf_q, r1_ovf_q, r0_err_q, r1_err_q;
  logic [CNT_W-1:0]  op_cnt_q;
  logic              gnt_any, gnt, accept, resp_hs;
  logic [32:0]       zz;
  logic              alu_ovf, alu_err;
  logic [4:0]        sh;
  logic [31:0]       sra_r;

  // Round-robin grant, only offered in IDLE; a tie goes to the port != last.
  always_comb begin
    gnt_any = (state_q == IDLE) && (r0_valid || r1_valid);
    gnt     = 1'b0;
    if (r0_valid && r1_valid) gnt = ~last_q;
    else if (r1_valid)        gnt = 1'b1;
  end

  assign r0_ready  = gnt_any && !gnt;
  assign r1_ready  = gnt_any && gnt;
  assign accept    = gnt_any;
  assign resp_hs   = (state_q == RESP) && (owner_q ? r1_rready : r0_rready);
  assign r0_rvalid = (state_q == RESP) && !owner_q;
  assign r1_rvalid = (state_q == RESP) && owner_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign op_cnt    = op_cnt_q;
  assign r0_z      = r0_z_q;
  assign r0_ovf    = r0_ovf_q;
  assign r0_err    = r0_err_q;
  assign r1_z      = r1_z_q;
  assign r1_ovf    = r1_ovf_q;
  assign r1_err    = r1_err_q;

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; last resets to 1 so r0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) last_q <= gnt;
    end
  end

  // Operation latch taken from the granted port on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (accept) begin
      owner_q <= gnt;
      op_q    <= gnt ? r1_op : r0_op;
      x_q     <= gnt ? r1_x  : r0_x;
      y_q     <= gnt ? r1_y  : r0_y;
    end
  end

  // Shared ALU: 33-bit intermediate so signed overflow is visible in zz[32]^zz[31].
  always_comb begin
    sh      = y_q[4:0];
    sra_r   = $signed(x_q) >>> sh;
    zz      = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        zz      = {x_q[31], x_q} + {y_q[31], y_q};
        alu_ovf = zz[32] ^ zz[31];
      end
      OP_SUB: begin
        zz      = {x_q[31], x_q} - {y_q[31], y_q};
        alu_ovf = zz[32] ^ zz[31];
      end
      OP_ADDU: zz = {1'b0, x_q} + {1'b0, y_q};
      OP_SUBU: zz = {1'b0, x_q} - {1'b0, y_q};
      OP_OR:   zz = {1'b0, x_q | y_q};
      OP_SLL:  zz = {1'b0, x_q << sh};
      OP_SRL:  zz = {1'b0, x_q >> sh};
      OP_SRA:  zz = {1'b0, sra_r};
      default: alu_err = 1'b1;
    endcase
  end

  // Result capture into the owner's registers at the end of EXEC; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_z_q   <= '0;
      r0_ovf_q <= 1'b0;
      r0_err_q <= 1'b0;
      r1_z_q   <= '0;
      r1_ovf_q <= 1'b0;
      r1_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      if (owner_q) begin
        r1_z_q   <= zz[31:0];
        r1_ovf_q <= alu_ovf;
        r1_err_q <= alu_err;
      end else begin
        r0_z_q   <= zz[31:0];
        r0_ovf_q <= alu_ovf;
        r0_err_q <= alu_err;
      end
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       op_cnt_q <= '0;
    else if (resp_hs) op_cnt_q <= op_cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, per-port expected
// queues filled at issue time and drained by a monitor on each result handshake.
module tb_alu_arbiter;

  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam int W = 34;

  logic        clk, rst_n;
  logic        r0_valid, r0_ready, r0_rvalid, r0_rready, r0_ovf, r0_err;
  logic        r1_valid, r1_ready, r1_rvalid, r1_rready, r1_ovf, r1_err;
  logic [5:0]  r0_op, r1_op;
  logic [31:0] r0_x, r0_y, r0_z, r1_x, r1_y, r1_z;
  logic        busy;
  logic [31:0] op_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int acc_port[$];
  int acc_cyc[$];

  alu_arbiter #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_x(r0_x), .r0_y(r0_y),
    .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_z(r0_z), .r0_ovf(r0_ovf), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_x(r1_x), .r1_y(r1_y),
    .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_z(r1_z), .r1_ovf(r1_ovf), .r1_err(r1_err),
    .busy(busy), .op_cnt(op_cnt), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: logs accepts and scores each result handshake against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r0_valid && r0_ready) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
      if (r1_valid && r1_ready) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
      if (r0_rvalid && r0_rready) begin
        if (exp0_q.size() == 0) chk("r0_unexpected_result", 64'(r0_z), 64'hDEAD);
        else chk("r0_result", 64'({r0_err, r0_ovf, r0_z}), 64'(exp0_q.pop_front()));
      end
      if (r1_rvalid && r1_rready) begin
        if (exp1_q.size() == 0) chk("r1_unexpected_result", 64'(r1_z), 64'hDEAD);
        else chk("r1_result", 64'({r1_err, r1_ovf, r1_z}), 64'(exp1_q.pop_front()));
      end
    end
  end

  // Driver: present a request on port p, hold until accepted, record expectation.
  // Called and returns at posedge+1.
  task automatic issue(input bit p, input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [31:0] ez, input logic eovf, input logic eerr,
                       output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    if (push) begin
      if (p) exp1_q.push_back({eerr, eovf, ez});
      else   exp0_q.push_back({eerr, eovf, ez});
    end
    if (p) begin r1_valid = 1'b1; r1_op = op; r1_x = x; r1_y = y; end
    else   begin r0_valid = 1'b1; r0_op = op; r0_x = x; r0_y = y; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (p ? r1_ready : r0_ready) got = 1'b1;
      else waits++;
    end
    if (!got) chk("accept_timeout", 64'(p), 64'hACCE);
    @(posedge clk); #1;
    if (p) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  // Wait (bounded) until all expected results are seen and the arbiter is idle.
  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp0_q.size() == 0 && exp1_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'(exp0_q.size() + exp1_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    chk("rst_r0_rvalid", 64'(r0_rvalid), 64'd0);
    chk("rst_r1_rvalid", 64'(r1_rvalid), 64'd0);
    chk("rst_outputs", 64'({r0_z, r0_ovf, r0_err}), 64'd0);
    chk("rst_r1_outputs", 64'({r1_z, r1_ovf, r1_err}), 64'd0);
    chk("rst_op_cnt", 64'(op_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int w;
  int hcyc;

  initial begin
    rst_n = 1'b0;
    r0_valid = 1'b0; r0_op = '0; r0_x = '0; r0_y = '0; r0_rready = 1'b1;
    r1_valid = 1'b0; r1_op = '0; r1_x = '0; r1_y = '0; r1_rready = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // r0 add 7+5: ready in first IDLE cycle, result two cycles after accept.
    issue(1'b0, OP_ADD, 32'd7, 32'd5, 1'b1, 32'd12, 1'b0, 1'b0, w);
    chk("t1_ready_first_cycle", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_exec_no_rvalid", 64'(r0_rvalid), 64'd0);
    chk("t1_exec_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_rvalid_at_T2", 64'(r0_rvalid), 64'd1);
    @(posedge clk); #1;
    wait_idle();
    chk("t1_op_cnt", 64'(op_cnt), 64'd1);

    // Both ports contending: strict alternation starting with r0, 3 cycles apart.
    do_reset();
    acc_port.delete(); acc_cyc.delete();
    fork
      begin
        issue(1'b0, OP_ADDU, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0, w);
        issue(1'b0, OP_ADDU, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0, w);
      end
      begin
        issue(1'b1, OP_SUBU, 32'd0, 32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, w);
        issue(1'b1, OP_SUBU, 32'd0, 32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, w);
      end
    join
    wait_idle();
    chk("t2_accept_count", 64'(acc_port.size()), 64'd4);
    if (acc_port.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant_%0d", i), 64'(acc_port[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) chk($sformatf("t2_spacing_%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
    end
    chk("t2_op_cnt", 64'(op_cnt), 64'd4);

    // Signed overflow on r1.
    issue(1'b1, OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h80000000, 1'b1, 1'b0, w);
    issue(1'b1, OP_SUB, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, w);
    issue(1'b1, OP_SUBU, 32'd5, 32'd3, 1'b1, 32'd2, 1'b0, 1'b0, w);

    // Shifts, OR and an unknown opcode on r0.
    issue(1'b0, OP_SRA, 32'h80000000, 32'h21, 1'b1, 32'hC0000000, 1'b0, 1'b0, w);
    issue(1'b0, OP_SRL, 32'h80000000, 32'h21, 1'b1, 32'h40000000, 1'b0, 1'b0, w);
    issue(1'b0, OP_SLL, 32'h00000003, 32'h04, 1'b1, 32'h00000030, 1'b0, 1'b0, w);
    issue(1'b0, OP_OR,  32'hA0A0A0A0, 32'h0A0A0A0A, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, w);
    issue(1'b0, 6'h3F,  32'h12345678, 32'h1, 1'b1, 32'h0, 1'b0, 1'b1, w);
    wait_idle();
    chk("t4_op_cnt", 64'(op_cnt), 64'd12);

    // Back-pressure: r0 result held 5 cycles, r1 blocked, then r1 accepted after handshake.
    r0_rready = 1'b0;
    issue(1'b0, OP_OR, 32'h000000F0, 32'h0000000F, 1'b1, 32'h000000FF, 1'b0, 1'b0, w);
    r1_valid = 1'b1; r1_op = OP_ADDU; r1_x = 32'd3; r1_y = 32'd4;
    exp1_q.push_back({1'b0, 1'b0, 32'd7});
    @(negedge clk);
    chk("t5_exec_r1_ready", 64'(r1_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_rvalid", 64'(r0_rvalid), 64'd1);
      chk("t5_hold_z", 64'(r0_z), 64'h000000FF);
      chk("t5_hold_busy", 64'(busy), 64'd1);
      chk("t5_hold_r1_ready", 64'(r1_ready), 64'd0);
    end
    @(posedge clk); #1;
    r0_rready = 1'b1;
    @(negedge clk);
    hcyc = cyc;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_idle_after_hs", 64'(dbg_state), 64'd0);
    chk("t5_r1_ready_next", 64'(r1_ready), 64'd1);
    chk("t5_next_cycle", 64'(cyc - hcyc), 64'd1);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    wait_idle();
    chk("t5_op_cnt", 64'(op_cnt), 64'd14);

    // Reset during EXEC discards the operation.
    do_reset();
    issue(1'b0, OP_ADD, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rvalid", 64'(r0_rvalid), 64'd0);
      chk("t6_op_cnt_zero", 64'(op_cnt), 64'd0);
    end
    @(posedge clk); #1;
    issue(1'b0, OP_ADD, 32'd100, 32'hFFFFFFFF, 1'b1, 32'd99, 1'b0, 1'b0, w);
    wait_idle();
    chk("t6_op_cnt_after", 64'(op_cnt), 64'd1);

    chk("exp0_drained", 64'(exp0_q.size()), 64'd0);
    chk("exp1_drained", 64'(exp1_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit integer ALU between two requesters (r0, r1) through valid/ready handshakes. Each accepted operation runs on the shared ALU and its result returns on the issuing port's response channel. Add/sub overflow and unknown opcodes are flagged per result. It sits between the decode/issue logic and the shared ALU, and is used where two pipelines or a pipeline plus a debug port need the same ALU.

## Interface
Parameters:
- `CNT_W`, default 32: width of the completed-operation counter.

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rN_valid` in 1 (N=0,1): request valid.
- `rN_ready` out 1: request accepted this cycle when high together with `rN_valid`.
- `rN_op` in 6: opcode, one of the `def.v` macros `add`, `sub`, `addu`, `subu`, `or`, `sll`, `srl`, `sra`.
- `rN_x`, `rN_y` in 32: operands; shift amount is `y[4:0]`.
- `rN_rvalid` out 1: result valid.
- `rN_rready` in 1: result consumed.
- `rN_z` out 32: result.
- `rN_ovf` out 1: signed overflow (`add`/`sub` only).
- `rN_err` out 1: unknown opcode.
- `busy` out 1: high in every state except IDLE.
- `op_cnt` out CNT_W: number of completed operations.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE -> EXEC on accept. EXEC -> RESP unconditionally. RESP -> IDLE when the owning port has `rvalid` and `rready` both high.
- Arbitration is round-robin with a 1-bit `last` pointer.
  - Grant is combinational and only in IDLE.
  - If exactly one `rN_valid` is high, grant that port.
  - If both are high, grant the port != `last`.
  - `rN_ready` = IDLE and grant==N. The other port's ready stays 0.
- On accept: latch op, x, y, and owner; set `last` = owner.
- The requester must hold `rN_valid` and its payload until ready. Dropping valid before accept is legal and means the request never occurred.
- EXEC: compute a 33-bit intermediate `zz`.
  - `add`/`sub`: sign-extend both operands to 33 bits, then add/subtract; `ovf` = `zz[32]^zz[31]`.
  - `addu`/`subu`: zero-extend; `ovf` = 0.
  - `or`: bitwise.
  - `sll`/`srl`: logical shifts by `y[4:0]`.
  - `sra`: arithmetic shift by `y[4:0]`.
  - Any other op: z = 0, err = 1, ovf = 0.
  - `z` = `zz[31:0]`.
  - Capture z/ovf/err into the owner's result register at the end of EXEC.
- RESP: owner's `rvalid` = 1. `z`/`ovf`/`err` stay stable until the handshake completes. The non-owner's `rvalid` = 0.
- `op_cnt` increments by 1 on each response handshake and wraps from all-ones to 0.
- `rN_z`, `rN_ovf`, and `rN_err` hold their last values after the handshake. They are only meaningful while `rvalid` is high.

## Timing
- Reset (asynchronous, `rst_n` low) forces:
  - state = IDLE, `last` = 1 (so r0 wins the first tie);
  - all `rN_rvalid` = 0, `rN_z` = 0, `rN_ovf` = 0, `rN_err` = 0;
  - `op_cnt` = 0, `busy` = 0.
  - `rN_ready` is then combinational on `rN_valid`.
- Reset mid-EXEC or mid-RESP discards the operation; no result is ever presented.
- Latency: accept edge at cycle T, EXEC during T+1, `rvalid` high from T+2.
- The earliest next accept is the cycle after the response handshake. Peak throughput is 1 op per 3 cycles with `rready` held high.
- A request arriving during EXEC or RESP waits; ready stays 0.
- A valid already high in the IDLE cycle is accepted in that cycle.

## Test plan
- Reset, then r0 only, op=`add`, x=7, y=5 -> r0_ready high in the first IDLE cycle; r0_rvalid two cycles later with z=12, ovf=0, err=0; op_cnt=1.
- Both valid every cycle, `addu` 1+1 on r0 and `subu` 0-1 on r1, rready=1, 4 ops -> grants r0,r1,r0,r1. r1 results z=0xFFFFFFFF, ovf=0. Each accept spaced 3 cycles apart.
- r1 `add` x=0x7FFFFFFF, y=1 -> z=0x80000000, ovf=1. r1 `sub` x=0x80000000, y=1 -> z=0x7FFFFFFF, ovf=1.
- r0 `sra` x=0x80000000, y=0x21 -> z=0xC0000000 (shift 1). `srl` same operands -> z=0x40000000. r0 op=0x3F -> z=0, err=1.
- r0 response with rready=0 for 5 cycles -> rvalid and z held, busy=1, r1_valid=1 sees r1_ready=0 throughout. On rready, state goes IDLE and r1 is accepted the next cycle.
- rst_n low during EXEC -> r0_rvalid never rises, op_cnt unchanged at 0, all outputs at reset values. After release, a new request completes normally.
